// File: rtl/cd_stack.sv
// cd_stack: parametrised single-cycle datapath with a 16-entry register file,
// an 8-op ALU with zero/carry flags and a hardware return-address stack.
// Program memory is external: pc_o is the fetch address and instr_i comes back
// in the same cycle. Control inputs come from a combinational decoder.
module cd_stack #(
   parameter int DW  = 8,   // data/register width, >= 8
   parameter int AW  = 10,  // PC width, <= 10
   parameter int RSD = 4,   // return-stack depth, >= 2
   parameter int LW  = 3    // width of stk_level, 2**LW > RSD
)(
   input  logic          clk,
   input  logic          reset,
   input  logic [15:0]   instr_i,
   output logic [AW-1:0] pc_o,
   input  logic          s_inc,
   input  logic          s_inm,
   input  logic          we3,
   input  logic          wez,
   input  logic          wec,
   input  logic [2:0]    op_alu,
   input  logic          push,
   input  logic          pop,
   output logic          z,
   output logic          c,
   output logic [5:0]    opcode,
   output logic [LW-1:0] stk_level,
   output logic          stk_ovf,
   output logic          stk_unf
);

   localparam int IW = (RSD > 1) ? $clog2(RSD) : 1;

   // ALU: returns {carry, result}; carry is meaningful only for add/sub.
   function automatic logic [DW:0] alu_calc(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      logic [DW:0] r;
      r = '0;
      case (op)
         3'b000:  r = {1'b0, a};
         3'b001:  r = {1'b0, ~a};
         3'b010:  r = {1'b0, a} + {1'b0, b};
         3'b011:  r = {(a < b), a - b};
         3'b100:  r = {1'b0, a & b};
         3'b101:  r = {1'b0, a | b};
         3'b110:  r = {1'b0, ~a + 1'b1};
         default: r = {1'b0, ~b + 1'b1};
      endcase
      return r;
   endfunction

   logic [DW-1:0] rf [16];
   logic [AW-1:0] stk [RSD];

   logic [3:0]    ra, rb, rd;
   logic [DW-1:0] rd_a, rd_b, imm, alu_res, wd;
   logic [DW:0]   alu_out;
   logic          alu_c, alu_z;

   logic [AW-1:0] pc_inc, pc_nxt;
   logic [LW-1:0] lvl_nxt, top_idx;
   logic          ovf_nxt, unf_nxt, do_push;

   assign opcode = instr_i[15:10];
   assign ra     = instr_i[11:8];
   assign rb     = instr_i[7:4];
   assign rd     = instr_i[3:0];
   assign imm    = DW'(instr_i[11:4]);

   // R0 is hard-wired to zero; reads see the value before this cycle's write.
   assign rd_a = (ra == 4'd0) ? '0 : rf[ra];
   assign rd_b = (rb == 4'd0) ? '0 : rf[rb];

   assign alu_out = alu_calc(op_alu, rd_a, rd_b);
   assign alu_res = alu_out[DW-1:0];
   assign alu_c   = alu_out[DW];
   assign alu_z   = (alu_res == '0);
   assign wd      = s_inm ? imm : alu_res;

   assign pc_inc  = pc_o + AW'(1);
   assign top_idx = stk_level - LW'(1);

   // Next PC and stack bookkeeping; pop outranks push and the jump.
   always_comb begin
      pc_nxt  = pc_inc;
      lvl_nxt = stk_level;
      ovf_nxt = stk_ovf;
      unf_nxt = stk_unf;
      do_push = 1'b0;
      if (pop) begin
         if (stk_level != '0) begin
            pc_nxt  = stk[IW'(top_idx)];
            lvl_nxt = top_idx;
         end else begin
            unf_nxt = 1'b1;
         end
      end else begin
         if (!s_inc)
            pc_nxt = instr_i[AW-1:0];
         if (push) begin
            if (stk_level < LW'(RSD)) begin
               do_push = 1'b1;
               lvl_nxt = stk_level + LW'(1);
            end else begin
               ovf_nxt = 1'b1;
            end
         end
      end
   end

   // Control state: PC, flags, stack level and sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_o      <= '0;
         z         <= 1'b0;
         c         <= 1'b0;
         stk_level <= '0;
         stk_ovf   <= 1'b0;
         stk_unf   <= 1'b0;
      end else begin
         pc_o      <= pc_nxt;
         stk_level <= lvl_nxt;
         stk_ovf   <= ovf_nxt;
         stk_unf   <= unf_nxt;
         if (wez) z <= alu_z;
         if (wec) c <= alu_c;
      end
   end

   // Register file write port; writes to R0 are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++)
            rf[i] <= '0;
      end else if (we3 && (rd != 4'd0)) begin
         rf[rd] <= wd;
      end
   end

   // Return-stack storage; entries above stk_level are never read, so no reset.
   always_ff @(posedge clk) begin
      if (do_push)
         stk[IW'(stk_level)] <= pc_inc;
   end

endmodule

// File: tb/tb_cd_stack.sv
// tb_cd_stack: table-driven bench for cd_stack with an expectation queue.
module tb_cd_stack;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr_i;
   logic [9:0]  pc_o;
   logic        s_inc, s_inm, we3, wez, wec, push, pop;
   logic [2:0]  op_alu;
   logic        z, c, stk_ovf, stk_unf;
   logic [5:0]  opcode;
   logic [2:0]  stk_level;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] instr;
      logic        s_inc, s_inm, we3, wez, wec;
      logic [2:0]  op;
      logic        push, pop;
      logic [9:0]  pc;
      logic        z, c;
      logic [2:0]  lvl;
      logic        ovf, unf;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   cd_stack #(.DW(8), .AW(10), .RSD(4), .LW(3)) dut (
      .clk(clk), .reset(reset), .instr_i(instr_i), .pc_o(pc_o),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .wec(wec),
      .op_alu(op_alu), .push(push), .pop(pop), .z(z), .c(c),
      .opcode(opcode), .stk_level(stk_level), .stk_ovf(stk_ovf),
      .stk_unf(stk_unf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] ins_r(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] d);
      return {4'h0, a, b, d};
   endfunction

   function automatic logic [15:0] ins_i(input logic [7:0] imm, input logic [3:0] d);
      return {4'h0, imm, d};
   endfunction

   function automatic logic [15:0] ins_j(input logic [9:0] t);
      return {6'h2A, t};
   endfunction

   function automatic vec_t mk(input logic [15:0] instr, input logic s_inc_v,
                               input logic s_inm_v, input logic we3_v,
                               input logic wez_v, input logic wec_v,
                               input logic [2:0] op, input logic push_v,
                               input logic pop_v, input logic [9:0] pc,
                               input logic zv, input logic cv,
                               input logic [2:0] lvl, input logic ovf,
                               input logic unf);
      vec_t r;
      r.instr = instr; r.s_inc = s_inc_v; r.s_inm = s_inm_v; r.we3 = we3_v;
      r.wez = wez_v; r.wec = wec_v; r.op = op; r.push = push_v; r.pop = pop_v;
      r.pc = pc; r.z = zv; r.c = cv; r.lvl = lvl; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_state(input string tag, input logic [9:0] pc, input logic zv,
                              input logic cv, input logic [2:0] lvl,
                              input logic ovf, input logic unf);
      chk({tag, ".pc"},  32'(pc_o),      32'(pc));
      chk({tag, ".z"},   32'(z),         32'(zv));
      chk({tag, ".c"},   32'(c),         32'(cv));
      chk({tag, ".lvl"}, 32'(stk_level), 32'(lvl));
      chk({tag, ".ovf"}, 32'(stk_ovf),   32'(ovf));
      chk({tag, ".unf"}, 32'(stk_unf),   32'(unf));
   endtask

   // Called just after a falling edge: drive, record expectation, clock, compare.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      instr_i = v.instr; s_inc = v.s_inc; s_inm = v.s_inm; we3 = v.we3;
      wez = v.wez; wec = v.wec; op_alu = v.op; push = v.push; pop = v.pop;
      exp_q.push_back(v);
      #1;
      chk($sformatf("v%0d.opcode", idx), 32'(opcode), 32'(v.instr[15:10]));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_state($sformatf("v%0d", idx), e.pc, e.z, e.c, e.lvl, e.ovf, e.unf);
      @(negedge clk);
   endtask

   initial begin
      // step-by-step program; pc column is the PC after the rising edge
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,0, 10'h001,0,0,3'd0,0,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,0, 10'h002,0,0,3'd0,0,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,0, 10'h003,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_i(8'hFF,4'd1),  1,1,1,0,0,3'd0,0,0, 10'h004,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_i(8'h01,4'd2),  1,1,1,0,0,3'd0,0,0, 10'h005,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_j(10'h020),     0,0,0,0,0,3'd0,1,0, 10'h020,0,0,3'd1,0,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,0, 10'h021,0,0,3'd1,0,0));
      tbl.push_back(mk(ins_j(10'h040),     0,0,0,0,0,3'd0,1,0, 10'h040,0,0,3'd2,0,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h022,0,0,3'd1,0,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h006,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,2,3),       1,0,1,1,1,3'd2,0,0, 10'h007,1,1,3'd0,0,0));
      tbl.push_back(mk(ins_r(2,1,4),       1,0,1,1,1,3'd3,0,0, 10'h008,0,1,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,2,5),       1,0,1,1,1,3'd3,0,0, 10'h009,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_i(8'h55,4'd0),  1,1,1,0,0,3'd0,0,0, 10'h00A,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(0,0,0),       1,0,0,1,1,3'd0,0,0, 10'h00B,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(3,0,0),       1,0,0,1,1,3'd0,0,0, 10'h00C,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(5,4,6),       1,0,1,1,1,3'd2,0,0, 10'h00D,1,1,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,0,0),       1,0,0,1,1,3'd1,0,0, 10'h00E,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(2,0,0),       1,0,0,1,1,3'd6,0,0, 10'h00F,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,0,0),       1,0,0,1,1,3'd7,0,0, 10'h010,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,2,0),       1,0,0,1,1,3'd4,0,0, 10'h011,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(0,0,0),       1,0,0,1,1,3'd5,0,0, 10'h012,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,2,0),       1,0,1,0,0,3'd2,0,0, 10'h013,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(1,2,0),       1,0,0,1,1,3'd2,0,0, 10'h014,1,1,3'd0,0,0));
      tbl.push_back(mk(ins_i(8'h70,4'd7),  1,1,1,1,1,3'd0,0,0, 10'h015,1,0,3'd0,0,0));
      tbl.push_back(mk(ins_r(7,0,0),       1,0,0,1,1,3'd0,0,0, 10'h016,0,0,3'd0,0,0));
      tbl.push_back(mk(ins_j(10'h100),     0,0,0,0,0,3'd0,1,0, 10'h100,0,0,3'd1,0,0));
      tbl.push_back(mk(ins_j(10'h110),     0,0,0,0,0,3'd0,1,0, 10'h110,0,0,3'd2,0,0));
      tbl.push_back(mk(ins_j(10'h120),     0,0,0,0,0,3'd0,1,0, 10'h120,0,0,3'd3,0,0));
      tbl.push_back(mk(ins_j(10'h130),     0,0,0,0,0,3'd0,1,0, 10'h130,0,0,3'd4,0,0));
      tbl.push_back(mk(ins_j(10'h140),     0,0,0,0,0,3'd0,1,0, 10'h140,0,0,3'd4,1,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h121,0,0,3'd3,1,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h111,0,0,3'd2,1,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h101,0,0,3'd1,1,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h017,0,0,3'd0,1,0));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h018,0,0,3'd0,1,1));
      tbl.push_back(mk(ins_j(10'h2AA),     0,0,0,0,0,3'd0,1,1, 10'h019,0,0,3'd0,1,1));
      tbl.push_back(mk(ins_j(10'h3FF),     0,0,0,0,0,3'd0,0,0, 10'h3FF,0,0,3'd0,1,1));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,0, 10'h000,0,0,3'd0,1,1));
      tbl.push_back(mk(ins_j(10'h3FF),     0,0,0,0,0,3'd0,0,0, 10'h3FF,0,0,3'd0,1,1));
      tbl.push_back(mk(ins_j(10'h050),     0,0,0,0,0,3'd0,1,0, 10'h050,0,0,3'd1,1,1));
      tbl.push_back(mk(16'h0000,           1,0,0,0,0,3'd0,0,1, 10'h000,0,0,3'd0,1,1));
      tbl.push_back(mk(ins_j(10'h060),     0,0,0,0,0,3'd0,1,0, 10'h060,0,0,3'd1,1,1));
      tbl.push_back(mk(ins_j(10'h070),     0,0,0,0,0,3'd0,1,0, 10'h070,0,0,3'd2,1,1));

      reset = 1'b0;
      instr_i = '0; s_inc = 1'b0; s_inm = 1'b0; we3 = 1'b0; wez = 1'b0;
      wec = 1'b0; op_alu = '0; push = 1'b0; pop = 1'b0;
      #3;
      check_state("reset", 10'h000, 0, 0, 3'd0, 0, 0);
      @(posedge clk);
      #1;
      check_state("reset_hold", 10'h000, 0, 0, 3'd0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], i);

      // asynchronous reset inside a nested call: clears state without a clock edge
      #2;
      reset = 1'b0;
      #1;
      check_state("async_rst", 10'h000, 0, 0, 3'd0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // stack must be empty afterwards: pop underflows and steps PC
      apply(mk(16'h0000, 1,0,0,0,0,3'd0,0,1, 10'h001,0,0,3'd0,0,1), 100);
      apply(mk(16'h0000, 1,0,0,0,0,3'd0,0,0, 10'h002,0,0,3'd0,0,1), 101);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
